// File: rtl/systolic_ctrl_if.sv
// Job handshake and operand/result strobe bundle between a job master and systolic_ctrl.
interface systolic_ctrl_if #(
    parameter int N     = 4,
    parameter int K_MAX = 16
);
    localparam int KW = $clog2(K_MAX + 1);
    localparam int AW = $clog2(K_MAX);
    localparam int RW = $clog2(N);

    logic          start;
    logic [KW-1:0] k_len;
    logic          abort;
    logic          busy;
    logic          done;
    logic          err;
    logic          clr_acc;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [N-1:0]  lane_en;
    logic          cap_en;
    logic [RW-1:0] cap_row;
    logic [31:0]   perf_cycles;
    logic [15:0]   perf_jobs;

    modport master (
        output start, k_len, abort,
        input  busy, done, err, clr_acc, rd_en, rd_addr, lane_en,
               cap_en, cap_row, perf_cycles, perf_jobs
    );

    modport slave (
        input  start, k_len, abort,
        output busy, done, err, clr_acc, rd_en, rd_addr, lane_en,
               cap_en, cap_row, perf_cycles, perf_jobs
    );
endinterface

// File: rtl/systolic_ctrl.sv
// Job sequencer for an NxN systolic MAC array: clear, skewed operand feed, drain, row capture.
// Optional busy-cycle / job counters are built only when SYS_CTRL_PERF_EN is defined.
module systolic_ctrl #(
    parameter int N         = 4,
    parameter int K_MAX     = 16,
    parameter int DRAIN_CYC = 12
) (
    input  logic         clk,
    input  logic         rst,
    systolic_ctrl_if.slave bus
);
    localparam int KW = $clog2(K_MAX + 1);
    localparam int AW = $clog2(K_MAX);
    localparam int RW = $clog2(N);
    localparam int CW = $clog2(K_MAX + N + DRAIN_CYC);

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, CAPTURE, DONE} state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [KW-1:0] klat, klat_d;
    logic          ill, ill_d;

    logic          busy_d, done_d, err_d, clr_d, rd_en_d, cap_en_d;
    logic [AW-1:0] rd_addr_d;
    logic [N-1:0]  lane_d;
    logic [RW-1:0] cap_row_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            klat        <= '0;
            ill         <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.err     <= 1'b0;
            bus.clr_acc <= 1'b0;
            bus.rd_en   <= 1'b0;
            bus.rd_addr <= '0;
            bus.lane_en <= '0;
            bus.cap_en  <= 1'b0;
            bus.cap_row <= '0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            klat        <= klat_d;
            ill         <= ill_d;
            bus.busy    <= busy_d;
            bus.done    <= done_d;
            bus.err     <= err_d;
            bus.clr_acc <= clr_d;
            bus.rd_en   <= rd_en_d;
            bus.rd_addr <= rd_addr_d;
            bus.lane_en <= lane_d;
            bus.cap_en  <= cap_en_d;
            bus.cap_row <= cap_row_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        klat_d  = klat;
        ill_d   = ill;
        unique case (state)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    cnt_d  = '0;
                    klat_d = bus.k_len;
                    if (bus.k_len == '0 || bus.k_len > KW'(K_MAX)) begin
                        ill_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        ill_d   = 1'b0;
                        state_d = CLEAR;
                    end
                end
            end
            CLEAR: begin
                state_d = FEED;
                cnt_d   = '0;
            end
            FEED: begin
                if (cnt == CW'(klat) + CW'(N - 2)) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            DRAIN: begin
                if (cnt == CW'(DRAIN_CYC - 1)) begin
                    state_d = CAPTURE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            CAPTURE: begin
                if (cnt == CW'(N - 1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                ill_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        // abort is honoured while a job is in flight; DONE always completes
        if (bus.abort && state != IDLE && state != DONE) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    // Outputs are decoded from the next state so they register alongside it
    always_comb begin
        busy_d   = (state_d != IDLE);
        clr_d    = (state_d == CLEAR);
        done_d   = (state_d == DONE);
        err_d    = (state_d == DONE) && ill_d;
        rd_en_d  = (state_d == FEED) && (cnt_d < CW'(klat_d));
        cap_en_d = (state_d == CAPTURE);
        lane_d   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            lane_d[i] = (state_d == FEED) && (cnt_d >= CW'(i))
                        && (cnt_d < CW'(i) + CW'(klat_d));
        end
        rd_addr_d = rd_en_d ? cnt_d[AW-1:0] : bus.rd_addr;
        cap_row_d = cap_en_d ? cnt_d[RW-1:0] : bus.cap_row;
    end

`ifdef SYS_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.perf_cycles <= '0;
            bus.perf_jobs   <= '0;
        end else begin
            if (bus.busy && bus.perf_cycles != '1)
                bus.perf_cycles <= bus.perf_cycles + 1'b1;
            if (bus.done && !bus.err)
                bus.perf_jobs <= bus.perf_jobs + 1'b1;
        end
    end
`else
    assign bus.perf_cycles = '0;
    assign bus.perf_jobs   = '0;
`endif
endmodule

// File: tb/tb_systolic_ctrl.sv
// Self-checking bench for systolic_ctrl: per-cycle comparison against a cycle-formula job model.
module tb_systolic_ctrl;
    localparam int N     = 4;
    localparam int K_MAX = 16;
    localparam int D     = 12;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    systolic_ctrl_if #(.N(N), .K_MAX(K_MAX)) bus();

    systolic_ctrl #(.N(N), .K_MAX(K_MAX), .DRAIN_CYC(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // model state: held address/row and expected perf counts
    logic [3:0] exp_addr;
    logic [1:0] exp_row;
    int         exp_pc;
    int         exp_jobs;

    logic [15:0] obs;
    assign obs = {bus.busy, bus.done, bus.err, bus.clr_acc, bus.rd_en, bus.rd_addr,
                  bus.lane_en, bus.cap_en, bus.cap_row};

    task automatic model_reset();
        exp_addr = '0;
        exp_row  = '0;
        exp_pc   = 0;
        exp_jobs = 0;
    endtask

    // Runs one job from its start cycle (0) to its last cycle, checking every cycle.
    // ab: cycle in which abort is raised (-1 none); s1/s2: extra start pulses (-1 none).
    task automatic run_job(input string name, input int k, input int ab,
                           input int s1, input int s2);
        bit legal;
        int kd, cs, last;
        legal = (k >= 1 && k <= K_MAX);
        kd    = k + 2*N + D + 1;
        cs    = k + N + D + 1;
        last  = legal ? kd : 1;
        if (ab >= 0) last = ab + 1;
        for (int c = 0; c <= last; c++) begin
            bit act, b, dn, er, clr, rde, cen;
            logic [N-1:0] ln;
            logic [15:0]  ev;
            logic [31:0]  epc;
            logic [15:0]  ejb;
            @(negedge clk);
            act = (ab < 0) || (c <= ab);
            b = 0; dn = 0; er = 0; clr = 0; rde = 0; cen = 0; ln = '0;
            if (!legal) begin
                b = (c == 1); dn = b; er = b;
            end else if (act) begin
                b   = (c >= 1 && c <= kd);
                clr = (c == 1);
                rde = (c >= 2 && c <= k + 1);
                for (int i = 0; i < N; i++) ln[i] = (c >= 2 + i && c <= k + 1 + i);
                cen = (c >= cs && c < cs + N);
                dn  = (c == kd);
            end
            if (rde) exp_addr = 4'(c - 2);
            if (cen) exp_row  = 2'(c - cs);
            ev = {b, dn, er, clr, rde, exp_addr, ln, cen, exp_row};
            checks++;
            if (obs !== ev) begin
                errors++;
                $display("FAIL %s cyc=%0d outputs got=%h exp=%h", name, c, obs, ev);
            end
`ifdef SYS_CTRL_PERF_EN
            epc = 32'(exp_pc);
            ejb = 16'(exp_jobs);
`else
            epc = '0;
            ejb = '0;
`endif
            checks++;
            if (bus.perf_cycles !== epc || bus.perf_jobs !== ejb) begin
                errors++;
                $display("FAIL %s cyc=%0d perf got=%0d/%0d exp=%0d/%0d",
                         name, c, bus.perf_cycles, bus.perf_jobs, epc, ejb);
            end
            exp_pc += int'(b);
            if (dn && !er) exp_jobs++;
            bus.start = (c == 0) || (c == s1) || (c == s2);
            bus.k_len = (c == 0) ? 5'(k) : 5'($urandom);
            bus.abort = (c == ab);
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.k_len = '0;
        bus.abort = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (obs !== 16'h0 || bus.perf_cycles !== 32'h0 || bus.perf_jobs !== 16'h0) begin
            errors++;
            $display("FAIL reset_state got=%h/%0d/%0d exp=0", obs, bus.perf_cycles, bus.perf_jobs);
        end
        rst = 1'b1;
    endtask

    task automatic test_basic();
        run_job("k8", 8, -1, -1, -1);
        run_job("k1", 1, -1, -1, -1);
        run_job("k16", 16, -1, -1, -1);
    endtask

    task automatic test_illegal();
        run_job("k0", 0, -1, -1, -1);
        run_job("k17", 17, -1, -1, -1);
        run_job("k31", 31, -1, -1, -1);
    endtask

    task automatic test_abort();
        run_job("abort_feed6", 8, 6, -1, -1);
        run_job("abort_with_start", 8, 0, -1, -1);
        run_job("abort_clear", 5, 1, -1, -1);
        run_job("abort_capture", 2, 2 + N + D + 2, -1, -1);
        run_job("abort_in_done", 3, 3 + 2*N + D + 1, -1, -1);
    endtask

    task automatic test_back_to_back();
        run_job("ignored_starts", 5, -1, 4, 5 + 2*N + D + 1);
        run_job("b2b_next", 6, -1, -1, -1);
    endtask

    task automatic test_perf();
        int base_pc, base_jobs;
        logic [31:0] epc;
        logic [15:0] ejb;
        base_pc   = exp_pc;
        base_jobs = exp_jobs;
        run_job("perf_k8", 8, -1, -1, -1);
        @(negedge clk);
`ifdef SYS_CTRL_PERF_EN
        epc = 32'(base_pc + 29);
        ejb = 16'(base_jobs + 1);
`else
        epc = '0;
        ejb = '0;
`endif
        checks++;
        if (bus.perf_cycles !== epc || bus.perf_jobs !== ejb) begin
            errors++;
            $display("FAIL perf_after_k8 got=%0d/%0d exp=%0d/%0d",
                     bus.perf_cycles, bus.perf_jobs, epc, ejb);
        end
        exp_pc = base_pc + 29;
    endtask

    task automatic test_reset_mid_feed();
        @(negedge clk);
        bus.start = 1'b1;
        bus.k_len = 5'd8;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (obs !== 16'h0 || bus.perf_cycles !== 32'h0 || bus.perf_jobs !== 16'h0) begin
            errors++;
            $display("FAIL reset_mid_feed got=%h/%0d/%0d exp=0", obs, bus.perf_cycles, bus.perf_jobs);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_reset got=%b exp=0", bus.busy);
        end
        run_job("post_reset_k3", 3, -1, -1, -1);
    endtask

    task automatic test_random();
        for (int j = 0; j < 25; j++) begin
            int k, ab;
            k  = int'($urandom_range(0, 20));
            ab = -1;
            if (k >= 1 && k <= K_MAX && $urandom_range(0, 2) == 0)
                ab = int'($urandom_range(0, k + 2*N + D + 1));
            run_job("random", k, ab, -1, -1);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_illegal();
        test_abort();
        test_back_to_back();
        test_perf();
        test_reset_mid_feed();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/systolic_ctrl.md
# systolic_ctrl

Sequencer for the N×N systolic array of 8-bit MAC PEs. It accepts a job (inner dimension `k_len`) over a start/done handshake and clears the array accumulators. It then drives read addresses into the A-row and B-column operand buffers and generates the diagonal skew lane enables that stagger operands into the array edges. It waits for the pipeline to drain, then steps a capture strobe across the N output rows.

## Interface
Parameters:
- `N`, 4: array dimension (rows = columns).
- `K_MAX`, 16: maximum inner dimension; operand buffer depth.
- `DRAIN_CYC`, 12: cycles waited after the last feed before capture.
- Derived: `KW = $clog2(K_MAX+1)`, `AW = $clog2(K_MAX)`, `RW = $clog2(N)`.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  job request; sampled only in IDLE.
- `k_len`  in  KW  inner dimension; sampled with `start`.
- `abort`  in  1  cancel the current job.
- `busy`  out  1  high in every non-IDLE state.
- `done`  out  1  one-cycle pulse at job end.
- `err`  out  1  one-cycle pulse with `done` on an illegal `k_len`.
- `clr_acc`  out  1  array accumulator clear.
- `rd_en`  out  1  operand buffer read enable (A and B share it).
- `rd_addr`  out  AW  operand buffer read address.
- `lane_en`  out  N  skew enable; bit i gates A row i and B column i.
- `cap_en`  out  1  result capture strobe.
- `cap_row`  out  RW  output row being captured.
- `perf_cycles`  out  32  busy-cycle counter (see Configuration).
- `perf_jobs`  out  16  completed-job counter (see Configuration).

## Operation
- Moore FSM states: IDLE, CLEAR, FEED, DRAIN, CAPTURE, DONE. All outputs are registered.
- IDLE: on `start`, latch `k_len`.
  - If `k_len == 0` or `k_len > K_MAX`, go to DONE with `err` set.
  - Otherwise go to CLEAR.
- CLEAR: one cycle with `clr_acc = 1`, then FEED.
- FEED: counter t runs 0 .. `k_len+N-2`.
  - `rd_en = (t < k_len)`; `rd_addr = t` while `rd_en`, else holds its last value.
  - `lane_en[i] = (i <= t < i+k_len)`, which produces a diagonal wavefront.
  - Exits to DRAIN after t = `k_len+N-2`.
- DRAIN: counter runs `DRAIN_CYC` cycles, then CAPTURE.
- CAPTURE: N cycles with `cap_en = 1` and `cap_row` = 0 .. N-1. Then DONE.
- DONE: one cycle with `done = 1` (`err = 1` if the job was illegal), then IDLE.
- `abort` in any state other than IDLE/DONE: IDLE next cycle.
  - `rd_en`, `lane_en`, `cap_en` and `clr_acc` go low in that cycle.
  - No `done` is issued.
- `abort` in DONE is ignored. `abort` together with `start` in IDLE: `abort` wins and the start is dropped.
- `start` outside IDLE is ignored and is not queued.
- Reset (asynchronous, at any time, including mid-job): state IDLE.
  - All outputs go to 0, including `rd_addr`, `cap_row` and the perf counters.
  - Counters and latched `k_len` clear.

## Timing
- Cycle 0 = the cycle in which `start` is sampled in IDLE.
- Legal job:
  - CLEAR is cycle 1.
  - FEED is cycles 2 .. `k_len+N`.
  - `rd_en` is high in cycles 2 .. `k_len+1`.
  - `lane_en[i]` is high in cycles 2+i .. `k_len+1+i`.
  - DRAIN lasts `DRAIN_CYC` cycles.
  - CAPTURE lasts N cycles.
  - `done` is high in cycle `k_len + 2N + DRAIN_CYC + 1`.
- Illegal job: `done` and `err` are high in cycle 1; no other strobe fires.
- A new `start` is accepted at the earliest in the cycle after `done`.
- Operand buffers have 1-cycle read latency. External skew registers align buffer data with `lane_en`; the controller does not delay `lane_en` for the read latency.

## Configuration
- `SYS_CTRL_PERF_EN` defined:
  - `perf_cycles` increments every cycle `busy` is high and saturates at 2^32-1.
  - `perf_jobs` increments on each `done` without `err` and wraps at 2^16.
  - Both clear only on reset.
- `SYS_CTRL_PERF_EN` undefined: the counters are not instantiated and both outputs are tied to 0.

## Test plan
All scenarios use N=4, K_MAX=16, DRAIN_CYC=12.
1. Assert `rst` low mid-FEED → all outputs 0 immediately. After release, `busy = 0`, and a new start with `k_len = 3` completes with `done` in cycle 24.
2. Start with `k_len = 8`:
   - `clr_acc` in cycle 1.
   - `rd_addr` 0..7 in cycles 2..9.
   - `lane_en[3]` high in cycles 5..12.
   - `cap_row` 0..3 in cycles 25..28.
   - `done` in cycle 29.
3. `k_len = 0` and `k_len = 17` → `done = err = 1` in cycle 1; `rd_en`, `clr_acc` and `cap_en` never rise.
4. `abort` in cycle 6 of a `k_len = 8` job → IDLE in cycle 7 with `busy`, `rd_en` and `lane_en` at 0 and no `done`. `perf_jobs` is unchanged.
5. `start` pulses during FEED and in the DONE cycle are ignored. A `start` in the cycle after `done` is accepted (CLEAR on the next cycle).
6. With `SYS_CTRL_PERF_EN`, after one `k_len = 8` job → `perf_cycles = 29` and `perf_jobs = 1`. Without the macro → both stay 0.
